// File: rtl/dff_pipe_monitor_pkg.sv
// Shared types for the dff_pipe_monitor checker: FSM states, error codes and
// the priority encoder that classifies the first failure of a cycle.
package dff_mon_pkg;

  typedef enum logic [1:0] {
    RST_CHK = 2'd0,
    ARMED   = 2'd1,
    FAIL    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RESET = 2'd1,
    ERR_DATA  = 2'd2,
    ERR_COMPL = 2'd3
  } err_code_t;

  // Reset outranks data, data outranks complement.
  function automatic err_code_t pick_code(input logic e_reset, input logic e_data,
                                          input logic e_compl);
    err_code_t code;
    code = ERR_NONE;
    if (e_reset)      code = ERR_RESET;
    else if (e_data)  code = ERR_DATA;
    else if (e_compl) code = ERR_COMPL;
    return code;
  endfunction

endpackage

// File: rtl/dff_pipe_monitor_if.sv
// Observed pipeline bus: stage enable, data in, and the q/qbar outputs.
// The DUT/driver side uses master; the monitor only listens through slave.
interface dff_pipe_monitor_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  modport master (output en, d, q, qbar);
  modport slave  (input  en, d, q, qbar);
endinterface

// File: rtl/dff_pipe_monitor_ref_pipe.sv
// Shadow copy of the observed pipeline: DEPTH enabled stages, o_exp is the
// value the DUT q must show at the next edge.
module dff_ref_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_exp
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_exp = r_stage[DEPTH-1];

endmodule

// File: rtl/dff_pipe_monitor.sv
// Passive checker for an enabled q/qbar register pipeline: sticky flags, a
// saturating error count and a first-failure record. Define DFF_MON_ASSERT_EN for SVA.
module dff_pipe_monitor
  import dff_mon_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  dff_pipe_monitor_if.slave  mon,
  input  logic               clr_err,
  output logic               err_reset,
  output logic               err_data,
  output logic               err_compl,
  output logic [CNT_W-1:0]   err_count,
  output logic               first_err_vld,
  output logic [1:0]         first_err_code,
  output logic [WIDTH-1:0]   first_err_exp,
  output logic [WIDTH-1:0]   first_err_got,
  output state_t             dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] w_exp;
  logic             w_data_mis, w_compl_mis;
  logic             w_e_reset, w_e_data, w_e_compl, w_any;
  err_code_t        w_code;

  state_t           r_state;
  logic             r_err_reset, r_err_data, r_err_compl;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vld;
  err_code_t        r_code;
  logic [WIDTH-1:0] r_exp, r_got;

  dff_ref_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ref (
    .clk   (clk),
    .rst   (rst),
    .i_en  (mon.en),
    .i_d   (mon.d),
    .o_exp (w_exp)
  );

  assign w_data_mis  = (mon.q != w_exp);
  assign w_compl_mis = (mon.qbar != ~mon.q);
  // The first edge after reset release reclassifies a data mismatch as a reset error.
  assign w_e_reset   = (r_state == RST_CHK) && w_data_mis;
  assign w_e_data    = (r_state != RST_CHK) && w_data_mis;
  assign w_e_compl   = w_compl_mis;
  assign w_any       = w_e_reset || w_e_data || w_e_compl;
  assign w_code      = pick_code(w_e_reset, w_e_data, w_e_compl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RST_CHK;
      r_err_reset <= 1'b0;
      r_err_data  <= 1'b0;
      r_err_compl <= 1'b0;
      r_cnt       <= '0;
      r_vld       <= 1'b0;
      r_code      <= ERR_NONE;
      r_exp       <= '0;
      r_got       <= '0;
    end else begin
      if (clr_err) begin
        // A same-edge error survives the clear and restarts the history.
        r_err_reset <= w_e_reset;
        r_err_data  <= w_e_data;
        r_err_compl <= w_e_compl;
        r_cnt       <= w_any ? CNT_ONE : '0;
        r_vld       <= w_any;
        r_code      <= w_any ? w_code : ERR_NONE;
        r_exp       <= w_any ? w_exp : '0;
        r_got       <= w_any ? mon.q : '0;
      end else begin
        r_err_reset <= r_err_reset | w_e_reset;
        r_err_data  <= r_err_data  | w_e_data;
        r_err_compl <= r_err_compl | w_e_compl;
        if (w_any && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_ONE;
        if (w_any && !r_vld) begin
          r_vld  <= 1'b1;
          r_code <= w_code;
          r_exp  <= w_exp;
          r_got  <= mon.q;
        end
      end

      case (r_state)
        RST_CHK: r_state <= w_any ? FAIL : ARMED;
        ARMED:   if (w_any) r_state <= FAIL;
        FAIL:    if (clr_err && !w_any) r_state <= ARMED;
        default: r_state <= RST_CHK;
      endcase
    end
  end

  assign err_reset      = r_err_reset;
  assign err_data       = r_err_data;
  assign err_compl      = r_err_compl;
  assign err_count      = r_cnt;
  assign first_err_vld  = r_vld;
  assign first_err_code = r_code;
  assign first_err_exp  = r_exp;
  assign first_err_got  = r_got;
  assign dbg_state      = r_state;

`ifdef DFF_MON_ASSERT_EN
  a_reset: assert property (@(posedge clk) (!rst && r_state == RST_CHK) |-> !w_data_mis)
    else $error("dff_pipe_monitor reset check: exp=%h got=%h", w_exp, mon.q);
  c_reset: cover property (@(posedge clk) !rst && r_state == RST_CHK && w_data_mis);

  a_data: assert property (@(posedge clk) disable iff (rst) (r_state != RST_CHK) |-> !w_data_mis)
    else $error("dff_pipe_monitor data check: exp=%h got=%h", w_exp, mon.q);
  c_data: cover property (@(posedge clk) disable iff (rst) (r_state != RST_CHK) && w_data_mis);

  a_compl: assert property (@(posedge clk) disable iff (rst) !w_compl_mis)
    else $error("dff_pipe_monitor complement check: exp=%h got=%h", ~mon.q, mon.qbar);
  c_compl: cover property (@(posedge clk) disable iff (rst) w_compl_mis);
`endif

endmodule

// File: tb/tb_dff_pipe_monitor.sv
// Bench for dff_pipe_monitor: a fake DUT pipeline with fault knobs drives the
// bus; a queue-based reference of the checking rules predicts every output.
module tb_dff_pipe_monitor;
  import dff_mon_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr_err = 1'b0;
  logic             err_reset, err_data, err_compl, first_err_vld;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       first_err_code;
  logic [W-1:0]     first_err_exp, first_err_got;
  state_t           dbg_state;

  dff_pipe_monitor_if #(.WIDTH(W)) ifc ();

  always #5 clk = ~clk;

  dff_pipe_monitor #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .mon            (ifc),
    .clr_err        (clr_err),
    .err_reset      (err_reset),
    .err_data       (err_data),
    .err_compl      (err_compl),
    .err_count      (err_count),
    .first_err_vld  (first_err_vld),
    .first_err_code (first_err_code),
    .first_err_exp  (first_err_exp),
    .first_err_got  (first_err_got),
    .dbg_state      (dbg_state)
  );

  // ---------------- fake DUT pipeline with fault knobs ----------------
  logic [W-1:0] pipe_s [DEPTH];
  bit           adv_fault, q_frc_en, qb_frc_en;
  logic [W-1:0] q_frc, qb_frc;

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit           m_first, m_failing, m_er, m_ed, m_ec, m_vld;
  int           m_cnt, m_code;
  logic [W-1:0] m_exp, m_got;
  int           n_tests = 0;
  int           n_fail  = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         en;
    logic         adv;
    logic         e_data;
    logic         e_compl;
    int           e_cnt;
  } vec_t;

  vec_t t1[3];
  vec_t t3[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('0);
    m_first = 1; m_failing = 0;
    m_er = 0; m_ed = 0; m_ec = 0; m_vld = 0;
    m_cnt = 0; m_code = 0; m_exp = '0; m_got = '0;
  endtask

  // Applies the checking rules to what the monitor sees at one edge.
  task automatic model_edge(input logic [W-1:0] d, input logic en, input logic clr,
                            input logic [W-1:0] q, input logic [W-1:0] qb);
    logic [W-1:0] e;
    bit dm, er, ed, ec, any;
    int code;
    e   = exp_q[0];
    dm  = (q != e);
    er  = m_first && dm;
    ed  = !m_first && dm;
    ec  = (qb != ~q);
    any = er || ed || ec;
    code = er ? 1 : (ed ? 2 : 3);
    if (clr) begin
      m_er = er; m_ed = ed; m_ec = ec;
      m_cnt = any ? 1 : 0;
      m_vld = any;
      m_code = any ? code : 0;
      m_exp = any ? e : '0;
      m_got = any ? q : '0;
      m_failing = any;
    end else begin
      m_er = m_er || er; m_ed = m_ed || ed; m_ec = m_ec || ec;
      if (any && m_cnt < CMAX) m_cnt++;
      if (any && !m_vld) begin
        m_vld = 1; m_code = code; m_exp = e; m_got = q;
      end
      if (any) m_failing = 1;
    end
    m_first = 0;
    if (en) begin
      exp_q.push_back(d);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_model(input string tag);
    state_t es;
    es = m_first ? RST_CHK : (m_failing ? FAIL : ARMED);
    chk({tag, ".err_reset"}, 32'(err_reset), 32'(m_er));
    chk({tag, ".err_data"},  32'(err_data),  32'(m_ed));
    chk({tag, ".err_compl"}, 32'(err_compl), 32'(m_ec));
    chk({tag, ".err_count"}, 32'(err_count), m_cnt);
    chk({tag, ".vld"},       32'(first_err_vld), 32'(m_vld));
    chk({tag, ".code"},      32'(first_err_code), m_code);
    chk({tag, ".exp"},       32'(first_err_exp), 32'(m_exp));
    chk({tag, ".got"},       32'(first_err_got), 32'(m_got));
    chk({tag, ".state"},     32'(dbg_state), 32'(es));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a negedge; returns just after the next negedge.
  task automatic drive(input logic [W-1:0] d_i, input logic en_i, input logic clr_i);
    logic [W-1:0] qv;
    qv       = q_frc_en ? q_frc : pipe_s[DEPTH-1];
    ifc.d    = d_i;
    ifc.en   = en_i;
    ifc.q    = qv;
    ifc.qbar = qb_frc_en ? qb_frc : ~qv;
    clr_err  = clr_i;
    model_edge(d_i, en_i, clr_i, qv, ifc.qbar);
    @(posedge clk);
    if (en_i || adv_fault) begin
      for (int i = DEPTH - 1; i > 0; i--) pipe_s[i] = pipe_s[i-1];
      pipe_s[0] = d_i;
    end
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // Asserts reset away from any clock edge and checks the outputs clear at once.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    adv_fault = 0; q_frc_en = 0; qb_frc_en = 0;
    for (int i = 0; i < DEPTH; i++) pipe_s[i] = '0;
    ifc.en = 1'b0; ifc.d = '0; ifc.q = '0; ifc.qbar = '1;
    clr_err = 1'b0;
    model_reset();
    #1;
    check_model({tag, ".async_rst"});
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    adv_fault = v.adv;
    drive(v.d, v.en, 1'b0);
    adv_fault = 0;
    chk({tag, ".tbl_data"},  32'(err_data),  32'(v.e_data));
    chk({tag, ".tbl_compl"}, 32'(err_compl), 32'(v.e_compl));
    chk({tag, ".tbl_cnt"},   32'(err_count), v.e_cnt);
    chk({tag, ".tbl_reset"}, 32'(err_reset), 32'd0);
    check_model(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Correct DUT, three enabled edges: no errors anywhere.
    t1[0] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    t1[1] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    t1[2] = '{8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    // Stalled pipeline that the faulty DUT advances anyway.
    t3[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    t3[1] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    t3[2] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    t3[3] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    t3[4] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 3};
    t3[5] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 3};

    // 1: clean propagation
    do_reset("t1");
    for (int i = 0; i < 3; i++) run_vec(t1[i], $sformatf("t1[%0d]", i));

    // 2: wrong q at the first edge after release
    do_reset("t2");
    q_frc_en = 1; q_frc = 8'h01;
    drive(8'h44, 1'b1, 1'b0);
    q_frc_en = 0;
    chk("t2.err_reset", 32'(err_reset), 32'd1);
    chk("t2.err_data",  32'(err_data), 32'd0);
    chk("t2.code",      32'(first_err_code), 32'd1);
    chk("t2.exp",       32'(first_err_exp), 32'h00);
    chk("t2.got",       32'(first_err_got), 32'h01);
    check_model("t2");
    drive(8'h45, 1'b1, 1'b0);
    check_model("t2.after");

    // 3: erroneous advance while en=0
    do_reset("t3");
    for (int i = 0; i < 6; i++) run_vec(t3[i], $sformatf("t3[%0d]", i));
    chk("t3.code", 32'(first_err_code), 32'd2);
    chk("t3.got",  32'(first_err_got), 32'hA5);

    // 4: qbar stuck equal to q, count saturates
    do_reset("t4");
    repeat (3) begin drive(8'h3C, 1'b1, 1'b0); check_model("t4.fill"); end
    qb_frc_en = 1; qb_frc = 8'h3C;
    repeat (20) begin drive(8'h3C, 1'b1, 1'b0); check_model("t4"); end
    qb_frc_en = 0;
    chk("t4.err_compl", 32'(err_compl), 32'd1);
    chk("t4.err_data",  32'(err_data), 32'd0);
    chk("t4.err_count", 32'(err_count), 32'd15);
    chk("t4.code",      32'(first_err_code), 32'd3);

    // 5: clear and data error on the same edge
    q_frc_en = 1; q_frc = 8'h55;
    drive(8'h3C, 1'b1, 1'b1);
    q_frc_en = 0;
    chk("t5.err_data",  32'(err_data), 32'd1);
    chk("t5.err_compl", 32'(err_compl), 32'd0);
    chk("t5.err_count", 32'(err_count), 32'd1);
    chk("t5.state",     32'(dbg_state), 32'(FAIL));
    chk("t5.code",      32'(first_err_code), 32'd2);
    chk("t5.exp",       32'(first_err_exp), 32'h3C);
    chk("t5.got",       32'(first_err_got), 32'h55);
    check_model("t5");
    drive(8'h3C, 1'b1, 1'b1);
    chk("t5.clr_state", 32'(dbg_state), 32'(ARMED));
    chk("t5.clr_count", 32'(err_count), 32'd0);
    check_model("t5.clr");

    // 6: reset while FAIL, then clean running
    q_frc_en = 1; q_frc = 8'hFF;
    drive(8'h3C, 1'b1, 1'b0);
    q_frc_en = 0;
    chk("t6.pre_state", 32'(dbg_state), 32'(FAIL));
    #2;
    do_reset("t6");
    repeat (10) begin
      drive(W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      check_model("t6.run");
    end
    chk("t6.err_count", 32'(err_count), 32'd0);

    // Random traffic with sparse faults, clears and resets.
    do_reset("rnd");
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd");
      q_frc_en  = ($urandom_range(0, 19) == 0);
      q_frc     = W'($urandom_range(0, 255));
      qb_frc_en = ($urandom_range(0, 19) == 0);
      qb_frc    = W'($urandom_range(0, 255));
      adv_fault = ($urandom_range(0, 29) == 0);
      drive(W'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
      check_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
